unidade_busca_instrucao: RTL and testbench

//  Fetch-side initiator for the synchronous instruction memory. Holds the 8-bit PC,

---
 rtl/unidade_busca_instrucao.sv | 126 ++++++++++++
 tb/tb_unidade_busca_instrucao.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca_instrucao.sv
// Fetch unit: drives the instruction memory address, captures the returned
// word into a small prefetch FIFO and hands {PC, instruction} to decode.
module unidade_busca_instrucao #(
   parameter int LARGURA_END  = 8,
   parameter int LARGURA_INST = 8,
   parameter int PROFUNDIDADE = 2,
   parameter logic [LARGURA_END-1:0] END_INICIAL = '0
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    Habilita,
   output logic [LARGURA_END-1:0]  Endereco,
   input  logic [LARGURA_INST-1:0] Instrucao,
   input  logic                    Desvio,
   input  logic [LARGURA_END-1:0]  Alvo,
   input  logic                    Parada,
   output logic [LARGURA_INST-1:0] Instrucao_Saida,
   output logic [LARGURA_END-1:0]  PC_Saida,
   output logic                    Valido,
   input  logic                    Pronto
);

   localparam int CW = $clog2(PROFUNDIDADE + 1);
   localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
   localparam logic [PW-1:0] ULTIMO = PW'(PROFUNDIDADE - 1);
   localparam logic [CW:0]   LIMITE = (CW+1)'(PROFUNDIDADE);

   typedef enum logic [1:0] {
      OCIOSO,
      BUSCANDO,
      PARADO
   } estado_t;

   estado_t estado, prox_estado;

   logic [LARGURA_END-1:0]  pc;
   logic [LARGURA_END-1:0]  tag;
   logic                    em_voo;
   logic [LARGURA_END-1:0]  fila_pc   [PROFUNDIDADE];
   logic [LARGURA_INST-1:0] fila_inst [PROFUNDIDADE];
   logic [PW-1:0]           ptr_le;
   logic [PW-1:0]           ptr_esc;
   logic [CW-1:0]           conta;
   logic [CW:0]             ocupacao;
   logic                    desvia;
   logic                    retira;
   logic                    insere;
   logic                    emite;

   function automatic logic [PW-1:0] avanca(input logic [PW-1:0] p);
      return (p == ULTIMO) ? '0 : p + 1'b1;
   endfunction

   assign Endereco        = pc;
   assign Valido          = (conta != '0);
   assign PC_Saida        = fila_pc[ptr_le];
   assign Instrucao_Saida = fila_inst[ptr_le];

   assign desvia = Desvio && (estado != OCIOSO);
   assign retira = Valido && Pronto;
   assign insere = em_voo && !desvia;

   // Slots already promised: stored words plus the one in flight, less the pop.
   assign ocupacao = {1'b0, conta}
                   + {{CW{1'b0}}, em_voo}
                   - {{CW{1'b0}}, retira};

   assign emite = (estado == BUSCANDO) && !Parada && !Desvio
                && (ocupacao < LIMITE);

   always_comb begin
      prox_estado = estado;
      unique case (estado)
         OCIOSO:   if (Habilita) prox_estado = BUSCANDO;
         BUSCANDO: if (Parada)   prox_estado = PARADO;
         PARADO:   if (!Parada)  prox_estado = BUSCANDO;
         default:  prox_estado = OCIOSO;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) estado <= OCIOSO;
      else        estado <= prox_estado;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pc      <= END_INICIAL;
         tag     <= '0;
         em_voo  <= 1'b0;
         ptr_le  <= '0;
         ptr_esc <= '0;
         conta   <= '0;
      end else begin
         em_voo <= emite;
         if (emite) begin
            tag <= pc;
            pc  <= pc + 1'b1;
         end
         // A redirect drops queued words and the pending response.
         if (desvia) begin
            pc      <= Alvo;
            ptr_le  <= '0;
            ptr_esc <= '0;
            conta   <= '0;
         end else begin
            if (retira) ptr_le  <= avanca(ptr_le);
            if (insere) ptr_esc <= avanca(ptr_esc);
            conta <= conta + CW'(insere) - CW'(retira);
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < PROFUNDIDADE; i++) begin
            fila_pc[i]   <= '0;
            fila_inst[i] <= '0;
         end
      end else if (insere) begin
         fila_pc[ptr_esc]   <= tag;
         fila_inst[ptr_esc] <= Instrucao;
      end
   end

endmodule

// File: tb/tb_unidade_busca_instrucao.sv
// Bench for the fetch unit: directed scenarios plus a randomized run
// checked against an in-order stream model of the fetched addresses.
module tb_unidade_busca_instrucao;

   logic       clock    = 1'b0;
   logic       reset    = 1'b1;
   logic       habilita = 1'b0;
   logic       desvio   = 1'b0;
   logic       parada   = 1'b0;
   logic       pronto   = 1'b0;
   logic [7:0] alvo     = 8'h00;
   logic [7:0] instrucao = 8'h00;
   logic [7:0] endereco;
   logic [7:0] instrucao_saida;
   logic [7:0] pc_saida;
   logic       valido;

   int errors = 0;
   int checks = 0;

   unidade_busca_instrucao dut (
      .Clock           (clock),
      .Reset           (reset),
      .Habilita        (habilita),
      .Endereco        (endereco),
      .Instrucao       (instrucao),
      .Desvio          (desvio),
      .Alvo            (alvo),
      .Parada          (parada),
      .Instrucao_Saida (instrucao_saida),
      .PC_Saida        (pc_saida),
      .Valido          (valido),
      .Pronto          (pronto)
   );

   always #5 clock = ~clock;

   // Synchronous memory: mem[a] = a ^ A5, one cycle latency.
   always @(posedge clock) instrucao <= endereco ^ 8'hA5;

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic restart();
      reset    = 1'b0;
      habilita = 1'b0;
      desvio   = 1'b0;
      parada   = 1'b0;
      repeat (3) tick();
      reset    = 1'b1;
      habilita = 1'b1;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL rst_valido got=%b exp=0", valido); end
      checks++; if (endereco !== 8'h00) begin errors++; $display("FAIL rst_end got=%h exp=00", endereco); end
      checks++; if (pc_saida !== 8'h00) begin errors++; $display("FAIL rst_pc got=%h exp=00", pc_saida); end
      checks++; if (instrucao_saida !== 8'h00) begin errors++; $display("FAIL rst_inst got=%h exp=00", instrucao_saida); end
   endtask

   task automatic test_stream();
      logic [7:0] e;
      pronto = 1'b1;
      restart();
      tick();
      checks++; if (endereco !== 8'h00) begin errors++; $display("FAIL s1_end0 got=%h exp=00", endereco); end
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL s1_val0 got=%b exp=0", valido); end
      tick();
      checks++; if (endereco !== 8'h01) begin errors++; $display("FAIL s1_end1 got=%h exp=01", endereco); end
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL s1_val1 got=%b exp=0", valido); end
      tick();
      for (int k = 0; k < 10; k++) begin
         e = 8'(k);
         checks++; if (valido !== 1'b1) begin errors++; $display("FAIL s1_valido k=%0d got=%b exp=1", k, valido); end
         checks++; if (pc_saida !== e) begin errors++; $display("FAIL s1_pc got=%h exp=%h", pc_saida, e); end
         checks++; if (instrucao_saida !== (e ^ 8'hA5)) begin errors++; $display("FAIL s1_inst got=%h exp=%h", instrucao_saida, e ^ 8'hA5); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] e;
      pronto = 1'b0;
      restart();
      repeat (6) tick();
      checks++; if (valido !== 1'b1) begin errors++; $display("FAIL s2_valido got=%b exp=1", valido); end
      checks++; if (pc_saida !== 8'h00) begin errors++; $display("FAIL s2_pc got=%h exp=00", pc_saida); end
      checks++; if (instrucao_saida !== 8'hA5) begin errors++; $display("FAIL s2_inst got=%h exp=A5", instrucao_saida); end
      checks++; if (endereco !== 8'h02) begin errors++; $display("FAIL s2_end got=%h exp=02", endereco); end
      tick();
      checks++; if (endereco !== 8'h02) begin errors++; $display("FAIL s2_end_hold got=%h exp=02", endereco); end
      checks++; if (pc_saida !== 8'h00) begin errors++; $display("FAIL s2_pc_hold got=%h exp=00", pc_saida); end
      pronto = 1'b1;
      for (int k = 0; k < 6; k++) begin
         e = 8'(k);
         checks++; if (pc_saida !== e || valido !== 1'b1) begin errors++; $display("FAIL s2_resume_pc got=%h/%b exp=%h/1", pc_saida, valido, e); end
         checks++; if (instrucao_saida !== (e ^ 8'hA5)) begin errors++; $display("FAIL s2_resume_inst got=%h exp=%h", instrucao_saida, e ^ 8'hA5); end
         tick();
      end
   endtask

   task automatic test_desvio();
      logic [7:0] e;
      desvio = 1'b1;
      alvo   = 8'hF0;
      pronto = 1'b0;
      tick();
      desvio = 1'b0;
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL s3_flush got=%b exp=0", valido); end
      checks++; if (endereco !== 8'hF0) begin errors++; $display("FAIL s3_end got=%h exp=F0", endereco); end
      tick();
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL s3_stale got=%b exp=0", valido); end
      checks++; if (endereco !== 8'hF1) begin errors++; $display("FAIL s3_end1 got=%h exp=F1", endereco); end
      tick();
      checks++; if (endereco !== 8'hF2) begin errors++; $display("FAIL s3_end2 got=%h exp=F2", endereco); end
      pronto = 1'b1;
      for (int k = 0; k < 4; k++) begin
         e = 8'hF0 + 8'(k);
         checks++; if (pc_saida !== e || valido !== 1'b1) begin errors++; $display("FAIL s3_pc got=%h/%b exp=%h/1", pc_saida, valido, e); end
         checks++; if (instrucao_saida !== (e ^ 8'hA5)) begin errors++; $display("FAIL s3_inst got=%h exp=%h", instrucao_saida, e ^ 8'hA5); end
         tick();
      end
   endtask

   task automatic test_wrap();
      logic [7:0] e;
      desvio = 1'b1;
      alvo   = 8'hFE;
      pronto = 1'b1;
      tick();
      desvio = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         e = 8'hFE + 8'(k);
         checks++; if (pc_saida !== e || valido !== 1'b1) begin errors++; $display("FAIL s4_pc got=%h/%b exp=%h/1", pc_saida, valido, e); end
         checks++; if (instrucao_saida !== (e ^ 8'hA5)) begin errors++; $display("FAIL s4_inst got=%h exp=%h", instrucao_saida, e ^ 8'hA5); end
         tick();
      end
   endtask

   task automatic test_parada();
      int n;
      desvio = 1'b1;
      alvo   = 8'h40;
      pronto = 1'b1;
      tick();
      desvio = 1'b0;
      tick();
      tick();
      checks++; if (pc_saida !== 8'h40 || valido !== 1'b1) begin errors++; $display("FAIL s5_head got=%h/%b exp=40/1", pc_saida, valido); end
      parada = 1'b1;
      tick();
      checks++; if (pc_saida !== 8'h41 || valido !== 1'b1) begin errors++; $display("FAIL s5_inflight got=%h/%b exp=41/1", pc_saida, valido); end
      checks++; if (endereco !== 8'h42) begin errors++; $display("FAIL s5_end got=%h exp=42", endereco); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (valido !== 1'b0) begin errors++; $display("FAIL s5_idle_valido got=%b exp=0", valido); end
         checks++; if (endereco !== 8'h42) begin errors++; $display("FAIL s5_idle_end got=%h exp=42", endereco); end
      end
      parada = 1'b0;
      n = 0;
      while (!valido && n < 10) begin tick(); n++; end
      checks++; if (valido !== 1'b1) begin errors++; $display("FAIL s5_resume_timeout got=%b exp=1", valido); end
      checks++; if (pc_saida !== 8'h42) begin errors++; $display("FAIL s5_resume_pc got=%h exp=42", pc_saida); end
      checks++; if (instrucao_saida !== 8'hE7) begin errors++; $display("FAIL s5_resume_inst got=%h exp=E7", instrucao_saida); end
      tick();
      checks++; if (pc_saida !== 8'h43) begin errors++; $display("FAIL s5_next_pc got=%h exp=43", pc_saida); end
   endtask

   task automatic test_async_reset();
      int n;
      pronto = 1'b1;
      tick();
      checks++; if (valido !== 1'b1) begin errors++; $display("FAIL s6_pre_valido got=%b exp=1", valido); end
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL s6_valido got=%b exp=0", valido); end
      checks++; if (endereco !== 8'h00) begin errors++; $display("FAIL s6_end got=%h exp=00", endereco); end
      @(negedge clock);
      repeat (2) tick();
      reset = 1'b1;
      n = 0;
      while (!valido && n < 10) begin tick(); n++; end
      checks++; if (valido !== 1'b1) begin errors++; $display("FAIL s6_restart_timeout got=%b exp=1", valido); end
      checks++; if (pc_saida !== 8'h00 || instrucao_saida !== 8'hA5) begin errors++; $display("FAIL s6_first got=%h/%h exp=00/A5", pc_saida, instrucao_saida); end
      tick();
      checks++; if (pc_saida !== 8'h01 || instrucao_saida !== 8'hA4) begin errors++; $display("FAIL s6_second got=%h/%h exp=01/A4", pc_saida, instrucao_saida); end
   endtask

   // Model: decode sees consecutive addresses starting at 0, restarting at
   // Alvo after every redirect; the head, when valid, is the next expected.
   task automatic test_random();
      logic [7:0] exp_pc;
      logic       prev_dv;
      int         accepted;
      pronto = 1'b1;
      restart();
      tick();
      exp_pc   = 8'h00;
      prev_dv  = 1'b0;
      accepted = 0;
      for (int i = 0; i < 600; i++) begin
         if (prev_dv) begin
            checks++; if (valido !== 1'b0) begin errors++; $display("FAIL rnd_flush i=%0d got=%b exp=0", i, valido); end
         end
         if (valido) begin
            checks++; if (pc_saida !== exp_pc) begin errors++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, pc_saida, exp_pc); end
            checks++; if (instrucao_saida !== (exp_pc ^ 8'hA5)) begin errors++; $display("FAIL rnd_inst i=%0d got=%h exp=%h", i, instrucao_saida, exp_pc ^ 8'hA5); end
         end
         pronto = ($urandom_range(0, 3) != 0);
         desvio = ($urandom_range(0, 19) == 0);
         alvo   = 8'($urandom);
         if (parada) parada = ($urandom_range(0, 2) != 0);
         else        parada = ($urandom_range(0, 14) == 0);
         if (valido && pronto) begin
            exp_pc = exp_pc + 8'h01;
            accepted++;
         end
         if (desvio) exp_pc = alvo;
         prev_dv = desvio;
         tick();
      end
      desvio = 1'b0;
      parada = 1'b0;
      checks++; if (accepted < 100) begin errors++; $display("FAIL rnd_throughput got=%0d exp>=100", accepted); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_desvio();
      test_wrap();
      test_parada();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
